lsu_dm_port: RTL and testbench



---
 rtl/lsu_pkg.sv | 52 +++++
 rtl/lsu_dm_port_if.sv | 46 ++++
 rtl/lsu_load_ext.sv | 36 +++
 rtl/lsu_dm_port.sv | 171 +++++++++++++++++
 tb/tb_lsu_dm_port.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_pkg
//  Purpose  : Shared definitions for the lsu_dm_port load/store unit:
//             operation encodings, FSM state encoding, address widths and
//             small decode helpers.
//  Config   : LSU_HALF_EN (consumed by lsu_dm_port, not by this package)
//  Revision : 1.0  initial release
// ============================================================================
package lsu_pkg;

    localparam int LSU_BADDR_W = 12;    // byte address width
    localparam int LSU_WADDR_W = 10;    // word address width

    typedef enum logic [2:0] {
        LSU_LB  = 3'd0,
        LSU_LH  = 3'd1,
        LSU_LW  = 3'd2,
        LSU_LBU = 3'd3,
        LSU_LHU = 3'd4,
        LSU_SB  = 3'd5,
        LSU_SH  = 3'd6,
        LSU_SW  = 3'd7
    } lsu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC0 = 2'd1,
        S_ACC1 = 2'd2,
        S_RESP = 2'd3
    } lsu_state_e;

    function automatic logic lsu_is_store(input lsu_op_e op);
        return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
    endfunction

    function automatic logic lsu_is_half(input lsu_op_e op);
        return (op == LSU_LH) || (op == LSU_LHU) || (op == LSU_SH);
    endfunction

    function automatic logic lsu_is_word(input lsu_op_e op);
        return (op == LSU_LW) || (op == LSU_SW);
    endfunction

    // Words need both low address bits clear, halfwords need bit 0 clear.
    function automatic logic lsu_misaligned(input lsu_op_e op, input logic [1:0] lsb);
        return (lsu_is_word(op) && (lsb != 2'b00)) ||
               (lsu_is_half(op) && lsb[0]);
    endfunction

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/lsu_dm_port_if.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_dm_port_if
//  Purpose  : Bundles the request/response handshake and the data-memory
//             bus of the load/store unit.
//  Modports : slave  - the load/store unit (lsu_dm_port)
//             master - execute stage plus data memory (environment side)
//  Signals  : req_valid/req_ready/req_op/req_addr/req_wdata,
//             resp_valid/resp_err/resp_rdata,
//             mem_addr/mem_din/mem_we/mem_bmode/mem_bsel/mem_dout
//  Revision : 1.0  initial release
// ============================================================================
interface lsu_dm_port_if;
    import lsu_pkg::*;

    logic                   req_valid;
    logic                   req_ready;
    logic [2:0]             req_op;
    logic [LSU_BADDR_W-1:0] req_addr;
    logic [31:0]            req_wdata;

    logic                   resp_valid;
    logic                   resp_err;
    logic [31:0]            resp_rdata;

    logic [LSU_WADDR_W-1:0] mem_addr;
    logic [31:0]            mem_din;
    logic                   mem_we;
    logic                   mem_bmode;
    logic [1:0]             mem_bsel;
    logic [31:0]            mem_dout;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, mem_dout,
        output req_ready, resp_valid, resp_err, resp_rdata,
               mem_addr, mem_din, mem_we, mem_bmode, mem_bsel
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata, mem_dout,
        input  req_ready, resp_valid, resp_err, resp_rdata,
               mem_addr, mem_din, mem_we, mem_bmode, mem_bsel
    );

endinterface : lsu_dm_port_if
`default_nettype wire

// File: rtl/lsu_load_ext.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_load_ext
//  Purpose  : Combinational merge and sign/zero extension of captured load
//             data. Stores (and any non-load op) produce zero.
//  Ports    : i_op    operation code
//             i_lo    byte at the request address (low byte)
//             i_hi    byte at address+1 (halfword high byte)
//             i_word  full captured word
//             o_resp_rdata extended load result
//  Revision : 1.0  initial release
// ============================================================================
module lsu_load_ext
    import lsu_pkg::*;
(
    input  lsu_op_e     i_op,
    input  logic [7:0]  i_lo,
    input  logic [7:0]  i_hi,
    input  logic [31:0] i_word,
    output logic [31:0] o_resp_rdata
);

    always_comb begin
        o_resp_rdata = 32'h0;
        case (i_op)
            LSU_LB:  o_resp_rdata = {{24{i_lo[7]}}, i_lo};
            LSU_LBU: o_resp_rdata = {24'h0, i_lo};
            LSU_LH:  o_resp_rdata = {{16{i_hi[7]}}, i_hi, i_lo};
            LSU_LHU: o_resp_rdata = {16'h0, i_hi, i_lo};
            LSU_LW:  o_resp_rdata = i_word;
            default: o_resp_rdata = 32'h0;
        endcase
    end

endmodule : lsu_load_ext
`default_nettype wire

// File: rtl/lsu_dm_port.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_dm_port
//  Purpose  : Multi-cycle load/store unit driving a word/byte data memory.
//             One request at a time; halfwords are split into two byte
//             accesses. One response per request (data or error).
//  Ports    : clk    system clock, rising edge
//             rst_n  asynchronous active-low reset
//             bus    lsu_dm_port_if.slave (request, response, memory bus)
//  Config   : LSU_HALF_EN - when defined, LH/LHU/SH are supported; when
//             undefined they are rejected with an error response.
//  Revision : 1.0  initial release
// ============================================================================
module lsu_dm_port
    import lsu_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    lsu_dm_port_if.slave  bus
);

    lsu_state_e             r_state;
    lsu_op_e                r_op;
    logic                   r_ready;
    logic                   r_resp_valid;
    logic                   r_resp_err;
    logic [LSU_WADDR_W-1:0] r_mem_addr;
    logic [31:0]            r_mem_din;
    logic                   r_mem_we;
    logic                   r_mem_bmode;
    logic [1:0]             r_mem_bsel;
    logic [31:0]            r_word;
    logic [7:0]             r_lo;
    logic [7:0]             r_hi;
`ifdef LSU_HALF_EN
    logic [7:0]             r_whi;      // SH upper byte, written in ACC1
`endif

    lsu_op_e     w_op;
    logic        w_illegal;
    logic        w_reject;
    logic [31:0] w_ext;

    assign w_op = lsu_op_e'(bus.req_op);

`ifdef LSU_HALF_EN
    assign w_illegal = 1'b0;
`else
    assign w_illegal = lsu_is_half(w_op);
`endif

    assign w_reject = w_illegal | lsu_misaligned(w_op, bus.req_addr[1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_op         <= LSU_LB;
            r_ready      <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_din    <= 32'h0;
            r_mem_we     <= 1'b0;
            r_mem_bmode  <= 1'b0;
            r_mem_bsel   <= 2'b00;
            r_word       <= 32'h0;
            r_lo         <= 8'h0;
            r_hi         <= 8'h0;
`ifdef LSU_HALF_EN
            r_whi        <= 8'h0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_op    <= w_op;
                        r_ready <= 1'b0;
                        if (w_reject) begin
                            // No memory access; respond in the next cycle.
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                        end else begin
                            // Memory outputs are set up here so they are
                            // already valid throughout the ACC0 cycle.
                            r_state     <= S_ACC0;
                            r_mem_addr  <= bus.req_addr[LSU_BADDR_W-1:2];
                            r_mem_bmode <= ~lsu_is_word(w_op);
                            r_mem_bsel  <= bus.req_addr[1:0];
                            r_mem_we    <= lsu_is_store(w_op);
                            if (lsu_is_store(w_op)) begin
                                r_mem_din <= lsu_is_word(w_op) ? bus.req_wdata
                                                               : {24'h0, bus.req_wdata[7:0]};
                            end
`ifdef LSU_HALF_EN
                            r_whi <= bus.req_wdata[15:8];
`endif
                        end
                    end
                end

                S_ACC0: begin
                    // Capture both views; the extender picks what it needs.
                    r_word <= bus.mem_dout;
                    r_lo   <= bus.mem_dout[7:0];
`ifdef LSU_HALF_EN
                    if (lsu_is_half(r_op)) begin
                        r_state    <= S_ACC1;
                        r_mem_bsel <= r_mem_bsel + 2'd1;
                        if (lsu_is_store(r_op)) begin
                            r_mem_din <= {24'h0, r_whi};
                        end
                    end else
`endif
                    begin
                        r_state      <= S_RESP;
                        r_mem_we     <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                    end
                end

`ifdef LSU_HALF_EN
                S_ACC1: begin
                    r_hi         <= bus.mem_dout[7:0];
                    r_state      <= S_RESP;
                    r_mem_we     <= 1'b0;
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b0;
                end
`endif

                S_RESP: begin
                    r_state      <= S_IDLE;
                    r_ready      <= 1'b1;
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                end

                default: begin
                    r_state      <= S_IDLE;
                    r_ready      <= 1'b1;
                    r_mem_we     <= 1'b0;
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                end
            endcase
        end
    end

    lsu_load_ext u_load_ext (
        .i_op         (r_op),
        .i_lo         (r_lo),
        .i_hi         (r_hi),
        .i_word       (r_word),
        .o_resp_rdata (w_ext)
    );

    assign bus.req_ready  = r_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_err   = r_resp_err;
    // Data is only presented with a successful response; zero otherwise.
    assign bus.resp_rdata = (r_resp_valid && !r_resp_err) ? w_ext : 32'h0;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_din    = r_mem_din;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_bmode  = r_mem_bmode;
    assign bus.mem_bsel   = r_mem_bsel;

endmodule : lsu_dm_port
`default_nettype wire

// File: tb/tb_lsu_dm_port.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu_dm_port
//  Purpose  : Self-checking bench for lsu_dm_port with a byte-array
//             reference memory and a word/byte data-memory model.
//  Config   : LSU_HALF_EN selects whether halfword ops are expected to work.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lsu_dm_port;

`ifdef LSU_HALF_EN
    localparam bit HALF_EN = 1'b1;
`else
    localparam bit HALF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_dm_port_if bus ();

    lsu_dm_port u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference memory, byte granular, little-endian.
    logic [7:0] refb [0:4095];

    function automatic logic [31:0] pat(input int i);
        return (32'(i) * 32'h9E37_79B9) ^ 32'h3C5A_96E1;
    endfunction

    // Data memory seen by the DUT.
    logic [31:0] dmem [0:1023];
    bit          mem_inited;
    logic [7:0]  sel_byte;

    always @(posedge clk) begin
        if (!mem_inited) begin
            for (int i = 0; i < 1024; i++) dmem[i] <= pat(i);
            mem_inited <= 1'b1;
        end else if (bus.mem_we) begin
            if (bus.mem_bmode) dmem[bus.mem_addr][8*bus.mem_bsel +: 8] <= bus.mem_din[7:0];
            else               dmem[bus.mem_addr] <= bus.mem_din;
        end
    end

    assign sel_byte     = dmem[bus.mem_addr][8*bus.mem_bsel +: 8];
    assign bus.mem_dout = bus.mem_bmode ? {{24{sel_byte[7]}}, sel_byte} : dmem[bus.mem_addr];

    function automatic logic [31:0] ref_word(input logic [9:0] wa);
        return {refb[4*wa+3], refb[4*wa+2], refb[4*wa+1], refb[4*wa]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Expected outcome of one request from the architectural rules.
    task automatic model(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] wd,
                         output logic err, output logic [31:0] rd, output int lat, output int nwe);
        bit half, word, store;
        int nb;
        logic [31:0] v;
        half  = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
        word  = (op == 3'd2) || (op == 3'd7);
        store = (op >= 3'd5);
        nb    = word ? 4 : (half ? 2 : 1);
        err   = ((int'(addr) % nb) != 0) || (half && !HALF_EN);
        rd = 32'h0; lat = 1; nwe = 0;
        if (!err) begin
            lat = half ? 3 : 2;
            if (store) begin
                nwe = half ? 2 : 1;
                for (int i = 0; i < nb; i++) refb[int'(addr) + i] = wd[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < nb; i++) v[8*i +: 8] = refb[int'(addr) + i];
                case (op)
                    3'd0:    rd = {{24{v[7]}}, v[7:0]};
                    3'd1:    rd = {{16{v[15]}}, v[15:0]};
                    default: rd = v;
                endcase
            end
        end
    endtask

    task automatic do_req(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd);
        logic e_err; logic [31:0] e_rd; int e_lat, e_we;
        int lat, wes, k; bit got; logic [1:0] lane; logic e_bmode;
        model(op, addr, wd, e_err, e_rd, e_lat, e_we);
        e_bmode = !((op == 3'd2) || (op == 3'd7));
        rd = 32'h0;
        @(negedge clk);
        k = 0;
        while (!bus.req_ready && k < 10) begin @(negedge clk); k++; end
        check("req_ready", 32'(bus.req_ready), 32'h1);
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_addr = addr; bus.req_wdata = wd;
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 1; wes = 0; got = 1'b0; lane = addr[1:0];
        while (!got && lat <= 6) begin
            if (bus.mem_we) begin
                check("we_addr", 32'(bus.mem_addr), 32'(addr[11:2]));
                check("we_bmode", 32'(bus.mem_bmode), 32'(e_bmode));
                if (e_bmode) check("we_bsel", 32'(bus.mem_bsel), 32'(lane));
                lane = lane + 2'd1;
                wes++;
            end
            if (bus.resp_valid) begin
                got = 1'b1;
                rd  = bus.resp_rdata;
                check("resp_err", 32'(bus.resp_err), 32'(e_err));
                check("resp_rdata", bus.resp_rdata, e_rd);
                check("resp_latency", 32'(lat), 32'(e_lat));
            end else begin
                @(negedge clk);
                lat++;
            end
        end
        check("resp_seen", 32'(got), 32'h1);
        check("we_cycles", 32'(wes), 32'(e_we));
        check("mem_word", dmem[addr[11:2]], ref_word(addr[11:2]));
        @(negedge clk);
        check("resp_single", 32'(bus.resp_valid), 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic        e_err; logic [31:0] e_rd; int e_lat, e_we;
        int          nresp;
        logic [2:0]  r_op_t; logic [11:0] r_addr_t;

        for (int i = 0; i < 1024; i++)
            for (int b = 0; b < 4; b++) refb[4*i+b] = pat(i)[8*b +: 8];
        bus.req_valid = 1'b0; bus.req_op = 3'd0; bus.req_addr = 12'h0; bus.req_wdata = 32'h0;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready",  32'(bus.req_ready),  32'h1);
        check("rst_resp_v", 32'(bus.resp_valid), 32'h0);
        check("rst_err",    32'(bus.resp_err),   32'h0);
        check("rst_rdata",  bus.resp_rdata,      32'h0);
        check("rst_we",     32'(bus.mem_we),     32'h0);
        check("rst_addr",   32'(bus.mem_addr),   32'h0);
        check("rst_din",    bus.mem_din,         32'h0);
        check("rst_bmode",  32'(bus.mem_bmode),  32'h0);
        check("rst_bsel",   32'(bus.mem_bsel),   32'h0);

        // Directed sequence.
        do_req(3'd7, 12'h010, 32'hDEAD_BEEF, rd);
        do_req(3'd2, 12'h010, 32'h0, rd);
        check("lw_const", rd, 32'hDEAD_BEEF);
        do_req(3'd5, 12'h013, 32'h0000_00A5, rd);
        do_req(3'd0, 12'h013, 32'h0, rd);
        check("lb_const", rd, 32'hFFFF_FFA5);
        do_req(3'd3, 12'h013, 32'h0, rd);
        check("lbu_const", rd, 32'h0000_00A5);
        do_req(3'd6, 12'h022, 32'h0000_8001, rd);
        do_req(3'd1, 12'h022, 32'h0, rd);
        do_req(3'd4, 12'h022, 32'h0, rd);
        do_req(3'd2, 12'h011, 32'h0, rd);
        do_req(3'd6, 12'h021, 32'h0000_1234, rd);

        // Request held valid through a busy store: exactly one response.
        model(3'd7, 12'h040, 32'hCAFE_F00D, e_err, e_rd, e_lat, e_we);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = 3'd7; bus.req_addr = 12'h040; bus.req_wdata = 32'hCAFE_F00D;
        nresp = 0;
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            if (j <= 2) check("busy_ready_low", 32'(bus.req_ready), 32'h0);
            if (j == 3) begin
                check("busy_ready_back", 32'(bus.req_ready), 32'h1);
                bus.req_valid = 1'b0;
            end
            if (bus.resp_valid) nresp++;
        end
        check("busy_one_resp", 32'(nresp), 32'h1);
        check("busy_mem", dmem[10'h010], ref_word(10'h010));

        // Reset in the middle of a store.
        @(negedge clk);
`ifdef LSU_HALF_EN
        bus.req_valid = 1'b1; bus.req_op = 3'd6; bus.req_addr = 12'h032; bus.req_wdata = 32'h0000_5A3C;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(posedge clk);             // ACC0 closes: low byte written, now in ACC1
        #2;
        refb[12'h032] = 8'h3C;
`else
        bus.req_valid = 1'b1; bus.req_op = 3'd5; bus.req_addr = 12'h032; bus.req_wdata = 32'h0000_005A;
        @(negedge clk);
        bus.req_valid = 1'b0;       // mid ACC0: the write edge never comes
        #1;
`endif
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(bus.req_ready),  32'h1);
        check("mid_rst_resp",  32'(bus.resp_valid), 32'h0);
        check("mid_rst_we",    32'(bus.mem_we),     32'h0);
        check("mid_rst_addr",  32'(bus.mem_addr),   32'h0);
        check("mid_rst_din",   bus.mem_din,         32'h0);
        check("mid_rst_bmode", 32'(bus.mem_bmode),  32'h0);
        check("mid_rst_bsel",  32'(bus.mem_bsel),   32'h0);
        nresp = 0;
        repeat (2) begin @(negedge clk); if (bus.resp_valid) nresp++; end
        rst_n = 1'b1;
        repeat (3) begin @(negedge clk); if (bus.resp_valid) nresp++; end
        check("mid_rst_noresp", 32'(nresp), 32'h0);
        check("mid_rst_mem", dmem[10'h00C], ref_word(10'h00C));

        // Randomized traffic in a small window so loads often hit stores.
        for (int t = 0; t < 300; t++) begin
            r_op_t   = 3'($urandom_range(0, 7));
            r_addr_t = 12'($urandom_range(0, 127));
            do_req(r_op_t, r_addr_t, $urandom, rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_lsu_dm_port
`default_nettype wire
